// File: rtl/or_serial_arbiter_if.sv
// Bundle between the two requesters, the external OR cell and or_serial_arbiter.
// Handshake: req_x is a level held with data_x stable until the one-cycle gnt_x pulse; done pulses once per accepted operand.
interface or_serial_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             gnt_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_b;
  logic             or_a;
  logic             or_b;
  logic             or_y;
  logic             busy;
  logic             done;
  logic             result;
  logic             result_id;

  // Requesters plus the external OR cell.
  modport master (
    output req_a, data_a, req_b, data_b, or_y,
    input  gnt_a, gnt_b, or_a, or_b, busy, done, result, result_id
  );

  // The arbiter/controller.
  modport slave (
    input  req_a, data_a, req_b, data_b, or_y,
    output gnt_a, gnt_b, or_a, or_b, busy, done, result, result_id
  );
endinterface

// File: rtl/or_serial_arbiter.sv
// Round-robin arbiter that time-shares one external 2-input OR cell to OR-reduce
// a WIDTH-bit operand, one bit per cycle, returning the result tagged with the requester id.
module or_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  or_serial_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             id;
  logic             last_id;
  logic             gnt_a_q, gnt_b_q;
  logic             result_q, result_id_q;
  logic             grant, win_b;

  // Arbitration and sequencing; on contention the id that did not win last time goes first.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    win_b   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          grant   = 1'b1;
          win_b   = bus.req_b && (!bus.req_a || !last_id);
          state_n = RUN;
        end
      end
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      acc         <= 1'b0;
      id          <= 1'b0;
      last_id     <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      result_q    <= 1'b0;
      result_id_q <= 1'b0;
    end else begin
      state   <= state_n;
      gnt_a_q <= grant && !win_b;
      gnt_b_q <= grant && win_b;
      if (grant) begin
        sh      <= win_b ? bus.data_b : bus.data_a;
        acc     <= 1'b0;
        cnt     <= '0;
        id      <= win_b;
        last_id <= win_b;
      end
      if (state == RUN) begin
        acc <= bus.or_y;
        sh  <= sh >> 1;
        cnt <= cnt + CW'(1);
        // The cell output on the final bit is the completed reduction.
        if (cnt == LAST) begin
          result_q    <= bus.or_y;
          result_id_q <= id;
        end
      end
    end
  end

  assign bus.or_a      = (state == RUN) && acc;
  assign bus.or_b      = (state == RUN) && sh[0];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_or_serial_arbiter.sv
// Bench for or_serial_arbiter: directed table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_or_serial_arbiter;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg8, dbg2;
  int         n_tests = 0;
  int         n_fail  = 0;

  or_serial_arbiter_if #(.WIDTH(W)) bus ();
  or_serial_arbiter_if #(.WIDTH(2)) bus2 ();

  // External OR cells.
  assign bus.or_y  = bus.or_a | bus.or_b;
  assign bus2.or_y = bus2.or_a | bus2.or_b;

  or_serial_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg8));
  or_serial_arbiter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Invariants, sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_gnt_excl",  bus.gnt_a & bus.gnt_b, 0);
      check("inv_done_gnt",  bus.done & (bus.gnt_a | bus.gnt_b), 0);
      check("inv_busy_idle", bus.busy, (dbg8 != 2'd0));
      check("inv2_gnt_excl", bus2.gnt_a & bus2.gnt_b, 0);
      check("inv2_busy_idle", bus2.busy, (dbg2 != 2'd0));
    end
  end

  // ---------------- driver ----------------
  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the following IDLE cycle.
  task automatic do_op(input logic ra, input logic rb, input logic [W-1:0] da,
                       input logic [W-1:0] db, input logic eid, input logic eres,
                       input string nm);
    logic [W-1:0] wd, tr_a, tr_b, exp_a;
    logic         gid, rres, rid, dbusy;
    int           gcyc, dcyc;
    bus.req_a = ra; bus.req_b = rb; bus.data_a = da; bus.data_b = db;
    wd = eid ? db : da;
    gcyc = -1; dcyc = -1; tr_a = '0; tr_b = '0; gid = 1'b0;
    rres = 1'b0; rid = 1'b0; dbusy = 1'b0;
    for (int cyc = 1; cyc <= W + 6 && dcyc < 0; cyc++) begin
      @(negedge clk);
      if (gcyc < 0 && (bus.gnt_a || bus.gnt_b)) begin
        gcyc = cyc;
        gid  = bus.gnt_b;
        if (bus.gnt_a) bus.req_a = 1'b0;
        else           bus.req_b = 1'b0;
      end
      if (gcyc > 0 && cyc - gcyc < W) begin
        tr_a[cyc-gcyc] = bus.or_a;
        tr_b[cyc-gcyc] = bus.or_b;
      end
      if (bus.done) begin
        dcyc = cyc; rres = bus.result; rid = bus.result_id; dbusy = bus.busy;
      end
    end
    for (int k = 0; k < W; k++) begin
      logic [W-1:0] m;
      m = (W'(1) << k) - W'(1);
      exp_a[k] = |(wd & m);
    end
    check({nm, "_gnt_cycle"},  gcyc, 1);
    check({nm, "_gnt_id"},     gid, eid);
    check({nm, "_done_cycle"}, dcyc, W + 1);
    check({nm, "_result"},     rres, eres);
    check({nm, "_result_id"},  rid, eid);
    check({nm, "_or_b_trace"}, tr_b, wd);
    check({nm, "_or_a_trace"}, tr_a, exp_a);
    check({nm, "_busy_done"},  dbusy, 1);
    @(negedge clk);
    check({nm, "_busy_idle"},  bus.busy, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         ra, rb;
    logic [W-1:0] da, db;
    logic         eid, eres;
  } vec_t;

  vec_t tbl[6];

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];

  initial begin
    logic         pend_a, pend_b, last, eid, eres;
    logic [W-1:0] rda, rdb;
    int           prev, ndone;
    logic [1:0]   e;

    tbl[0] = '{ra:1, rb:0, da:8'h00, db:8'h00, eid:0, eres:0};
    tbl[1] = '{ra:0, rb:1, da:8'h00, db:8'h80, eid:1, eres:1};
    tbl[2] = '{ra:1, rb:1, da:8'h01, db:8'h00, eid:0, eres:1};
    tbl[3] = '{ra:1, rb:1, da:8'h00, db:8'h40, eid:1, eres:1};
    tbl[4] = '{ra:1, rb:0, da:8'h10, db:8'h00, eid:0, eres:1};
    tbl[5] = '{ra:1, rb:1, da:8'hFF, db:8'h00, eid:1, eres:0};

    bus.req_a = 0; bus.req_b = 0; bus.data_a = '0; bus.data_b = '0;
    bus2.req_a = 0; bus2.req_b = 0; bus2.data_a = '0; bus2.data_b = '0;

    // Reset values.
    do_reset();
    check("reset_outputs",
          {bus.gnt_a, bus.gnt_b, bus.or_a, bus.or_b, bus.busy, bus.done, bus.result, bus.result_id},
          8'h00);

    // Both requesters held from reset: strict alternation, done every WIDTH+2 cycles.
    bus.data_a = 8'h01; bus.data_b = 8'h00; bus.req_a = 1; bus.req_b = 1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    prev = -1; ndone = 0;
    for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        e = exp_q.pop_front();
        check("fair_id_result", {bus.result_id, bus.result}, e);
        if (prev < 0) check("fair_first_done", cyc, 9);
        else          check("fair_spacing", cyc - prev, 10);
        prev = cyc;
        ndone++;
      end
    end
    check("fair_done_count", ndone, 4);
    bus.req_a = 0; bus.req_b = 0;

    // Table-driven single operations from a fresh reset.
    do_reset();
    for (int i = 0; i < 6; i++)
      do_op(tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db, tbl[i].eid, tbl[i].eres,
            $sformatf("vec%0d", i));

    // Reset in RUN cycle 4: operation abandoned, no done, B served next.
    do_reset();
    bus.data_a = 8'hFF; bus.req_a = 1;
    @(negedge clk);
    check("abort_gnt_a", bus.gnt_a, 1);
    bus.req_a = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs_zero",
          {bus.gnt_a, bus.gnt_b, bus.or_a, bus.or_b, bus.busy, bus.done, bus.result, bus.result_id},
          8'h00);
    rst = 1'b0;
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_op(0, 1, 8'h00, 8'h80, 1, 1, "after_abort");

    // WIDTH=2 instance: done three cycles after the grant decision.
    bus2.req_a = 1; bus2.data_a = 2'b10;
    @(negedge clk);
    check("w2_gnt", bus2.gnt_a, 1);
    bus2.req_a = 0;
    repeat (2) @(negedge clk);
    check("w2_done_10", {bus2.done, bus2.result, bus2.result_id}, 3'b110);
    @(negedge clk);
    bus2.req_a = 1; bus2.data_a = 2'b00;
    @(negedge clk);
    check("w2_gnt2", bus2.gnt_a, 1);
    bus2.req_a = 0;
    repeat (2) @(negedge clk);
    check("w2_done_00", {bus2.done, bus2.result, bus2.result_id}, 3'b100);
    @(negedge clk);

    // Random traffic against a transaction-level round-robin model.
    do_reset();
    pend_a = 0; pend_b = 0; last = 1; rda = '0; rdb = '0;
    for (int n = 0; n < 2000; n++) begin
      while (!pend_a && !pend_b) begin
        if ($urandom_range(0, 1) == 1) begin
          pend_a = 1;
          rda = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        end
        if ($urandom_range(0, 1) == 1) begin
          pend_b = 1;
          rdb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        end
        if (!pend_a && !pend_b) @(negedge clk);
      end
      eid  = (pend_a && pend_b) ? !last : pend_b;
      eres = eid ? |rdb : |rda;
      do_op(pend_a, pend_b, rda, rdb, eid, eres, "rand");
      last = eid;
      if (eid) pend_b = 0; else pend_a = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
